seq_lock: RTL and testbench

Parametrised sequence lock. It accepts a stream of multi-bit code symbols and compares each complete attempt against a stored, reprogrammable code. It asserts `unlock` for a fixed hold window on a match and counts failed attempts. Once the failure limit is reached it enforces a timed lockout. It is the generalised successor to the single-bit serial combination lock and sits between the keypad/symbol decoder and the actuator driver.

---
 rtl/seq_lock.sv | 233 +++++++++++++++++++++++
 tb/tb_seq_lock.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_lock.sv
// rtl/seq_lock.sv - parametrised multi-symbol sequence lock with reprogrammable code
//
// Purpose: collects CODE_LEN symbols per attempt and compares them against a
// stored code. A match opens the lock for UNLOCK_CYC cycles. Failures are
// counted, and optionally trigger a timed lockout. While open, the code can be
// reprogrammed through a shadow buffer that is committed atomically.
//
// Optional feature macro: SEQ_LOCK_LOCKOUT_EN (defined = lockout state built,
// undefined = no lockout state or timer, lockout tied low).
//
// Ports:
//   clk         in   clock, all flops update on the falling edge
//   clear       in   asynchronous active-low reset
//   sym_valid   in   sym_in carries a symbol this cycle
//   sym_in      in   code symbol (SYM_W bits)
//   prog_en     in   reprogram request, honoured only while open
//   unlock      out  lock open (registered)
//   prog_busy   out  new code being entered
//   lockout     out  lockout active
//   attempt_err out  one-cycle pulse on a failed attempt
//   fail_cnt    out  consecutive failed attempts, saturating at MAX_FAIL
module seq_lock #(
  parameter int                            SYM_W       = 4,
  parameter int                            CODE_LEN    = 4,
  parameter logic [CODE_LEN*SYM_W-1:0]     DEF_CODE    = 16'h1234,
  parameter int                            UNLOCK_CYC  = 8,
  parameter int                            TIMEOUT_CYC = 32,
  parameter int                            MAX_FAIL    = 3,
  parameter int                            LOCKOUT_CYC = 64
) (
  input  logic                             clk,
  input  logic                             clear,
  input  logic                             sym_valid,
  input  logic [SYM_W-1:0]                 sym_in,
  input  logic                             prog_en,
  output logic                             unlock,
  output logic                             prog_busy,
  output logic                             lockout,
  output logic                             attempt_err,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int IDX_W  = $clog2(CODE_LEN);
  localparam int FC_W   = $clog2(MAX_FAIL+1);
  localparam int HOLD_W = $clog2(UNLOCK_CYC+1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC+1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN-1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_PROG
`ifdef SEQ_LOCK_LOCKOUT_EN
    , S_LOCKOUT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               match_q, match_d;
  logic [TO_W-1:0]    idle_q, idle_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FC_W-1:0]    fail_q, fail_d;
  logic [FC_W-1:0]    fail_inc;
  logic               unlock_q, unlock_d;
  logic               prog_busy_q, prog_busy_d;
  logic               attempt_err_q, attempt_err_d;
  // Element 0 is the first symbol entered (the MS symbol of DEF_CODE).
  logic [SYM_W-1:0]   code_q [CODE_LEN];
  logic [SYM_W-1:0]   code_d [CODE_LEN];
  logic [SYM_W-1:0]   shadow_q [CODE_LEN];
  logic [SYM_W-1:0]   shadow_d [CODE_LEN];
`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCKOUT_CYC+1);
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic               lockout_q, lockout_d;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    match_d       = match_q;
    idle_d        = idle_q;
    hold_d        = hold_q;
    fail_d        = fail_q;
    attempt_err_d = 1'b0;
    code_d        = code_q;
    shadow_d      = shadow_q;
    fail_inc      = (fail_q == FC_MAX) ? fail_q : fail_q + 1'b1;
`ifdef SEQ_LOCK_LOCKOUT_EN
    lock_d        = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sym_valid) begin
          match_d = (sym_in == code_q[0]);
          idx_d   = IDX_W'(1);
          idle_d  = '0;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (sym_valid) begin
          idle_d = '0;
          if (idx_q == LAST_IDX) begin
            if (match_q && (sym_in == code_q[idx_q])) begin
              state_d = S_OPEN;
              fail_d  = '0;
              hold_d  = HOLD_W'(UNLOCK_CYC);
            end else begin
              attempt_err_d = 1'b1;
              fail_d        = fail_inc;
              state_d       = S_IDLE;
`ifdef SEQ_LOCK_LOCKOUT_EN
              if (fail_inc == FC_MAX) begin
                state_d = S_LOCKOUT;
                lock_d  = LOCK_W'(LOCKOUT_CYC);
              end
`endif
            end
          end else begin
            // A wrong symbol only clears the flag; the attempt always runs to full length.
            match_d = match_q && (sym_in == code_q[idx_q]);
            idx_d   = idx_q + 1'b1;
          end
        end else if (idle_q == TO_LAST) begin
          idle_d  = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_OPEN: begin
        // Checked before expiry so a reprogram request on the last open cycle wins.
        if (prog_en && sym_valid) begin
          shadow_d[0] = sym_in;
          idx_d       = IDX_W'(1);
          hold_d      = '0;
          state_d     = S_PROG;
        end else if (hold_q <= HOLD_W'(1)) begin
          // Timer is loaded with UNLOCK_CYC; leaving at 1 gives exactly that many open cycles.
          hold_d  = '0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_PROG: begin
        if (!prog_en) begin
          state_d = S_IDLE;
        end else if (sym_valid) begin
          shadow_d[idx_q] = sym_in;
          if (idx_q == LAST_IDX) begin
            code_d  = shadow_d;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef SEQ_LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        if (lock_q <= LOCK_W'(1)) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    unlock_d    = (state_d == S_OPEN);
    prog_busy_d = (state_d == S_PROG);
`ifdef SEQ_LOCK_LOCKOUT_EN
    lockout_d   = (state_d == S_LOCKOUT);
`endif
  end

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      match_q       <= 1'b0;
      idle_q        <= '0;
      hold_q        <= '0;
      fail_q        <= '0;
      unlock_q      <= 1'b0;
      prog_busy_q   <= 1'b0;
      attempt_err_q <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
        code_q[i]   <= DEF_CODE[(CODE_LEN-1-i)*SYM_W +: SYM_W];
        shadow_q[i] <= '0;
      end
`ifdef SEQ_LOCK_LOCKOUT_EN
      lock_q        <= '0;
      lockout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      match_q       <= match_d;
      idle_q        <= idle_d;
      hold_q        <= hold_d;
      fail_q        <= fail_d;
      unlock_q      <= unlock_d;
      prog_busy_q   <= prog_busy_d;
      attempt_err_q <= attempt_err_d;
      code_q        <= code_d;
      shadow_q      <= shadow_d;
`ifdef SEQ_LOCK_LOCKOUT_EN
      lock_q        <= lock_d;
      lockout_q     <= lockout_d;
`endif
    end
  end

  assign unlock      = unlock_q;
  assign prog_busy   = prog_busy_q;
  assign attempt_err = attempt_err_q;
  assign fail_cnt    = fail_q;
`ifdef SEQ_LOCK_LOCKOUT_EN
  assign lockout     = lockout_q;
`else
  assign lockout     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_lock.sv
// tb/tb_seq_lock.sv - self-checking bench for seq_lock
module tb_seq_lock;

`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear;
  logic       sym_valid;
  logic [3:0] sym_in;
  logic       prog_en;
  logic       unlock;
  logic       prog_busy;
  logic       lockout;
  logic       attempt_err;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  seq_lock dut (
    .clk        (clk),
    .clear      (clear),
    .sym_valid  (sym_valid),
    .sym_in     (sym_in),
    .prog_en    (prog_en),
    .unlock     (unlock),
    .prog_busy  (prog_busy),
    .lockout    (lockout),
    .attempt_err(attempt_err),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       p;
    logic       u;
    logic       b;
    logic       l;
    logic       e;
    logic [1:0] f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [3:0] s, input logic p,
                              input logic u, input logic b, input logic l,
                              input logic e, input logic [1:0] f);
    vec_t r;
    r.v = v; r.s = s; r.p = p; r.u = u; r.b = b; r.l = l; r.e = e; r.f = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic u, input logic b, input logic l,
                         input logic e, input logic [1:0] f);
    chk({tag, ".unlock"}, 32'(unlock), 32'(u));
    chk({tag, ".prog_busy"}, 32'(prog_busy), 32'(b));
    chk({tag, ".lockout"}, 32'(lockout), 32'(l));
    chk({tag, ".attempt_err"}, 32'(attempt_err), 32'(e));
    chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(f));
  endtask

  // Drive inputs at the rising edge, let the DUT sample on the falling edge,
  // then return at the next rising edge where outputs are stable.
  task automatic cyc(input logic v, input logic [3:0] s, input logic p);
    sym_valid = v; sym_in = s; prog_en = p;
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic enter(input logic [15:0] code, input logic p);
    for (int k = 0; k < 4; k++) cyc(1'b1, code[15-4*k -: 4], p);
  endtask

  task automatic wait_closed(input string tag);
    for (int i = 0; i < 50 && unlock; i++) cyc(1'b0, 4'h0, 1'b0);
    chk(tag, 32'(unlock), 32'd0);
  endtask

  int  n;
  logic bad;

  initial begin
    clear = 1'b0; sym_valid = 1'b0; sym_in = '0; prog_en = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    chk_all("reset", 0, 0, 0, 0, 2'd0);
    clear = 1'b1;

    // Good code, then three failed attempts (back-to-back retries included).
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h2, 0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h3, 0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h4, 0, 1, 0, 0, 0, 2'd0));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].p);
      chk_all($sformatf("good[%0d]", i), tbl[i].u, tbl[i].b, tbl[i].l, tbl[i].e, tbl[i].f);
    end

    // Open window: symbols without prog_en are ignored and do not shorten it.
    n = 1;
    for (int i = 0; i < 30 && unlock; i++) begin
      cyc(1'b1, 4'(i), 1'b0);
      if (unlock) n++;
    end
    chk("hold_len", 32'(n), 32'd8);
    chk("hold_busy", 32'(prog_busy), 32'd0);

    tbl.delete();
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h2, 0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h3, 0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h5, 0, 0, 0, 0, 1, 2'd1));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 2'd1));
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 0, 2'd1));
    tbl.push_back(mk(1, 4'h2, 0, 0, 0, 0, 0, 2'd1));
    tbl.push_back(mk(1, 4'h3, 0, 0, 0, 0, 0, 2'd1));
    tbl.push_back(mk(1, 4'h5, 0, 0, 0, 0, 1, 2'd2));
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 0, 2'd2));
    tbl.push_back(mk(1, 4'h2, 0, 0, 0, 0, 0, 2'd2));
    tbl.push_back(mk(1, 4'h3, 0, 0, 0, 0, 0, 2'd2));
    tbl.push_back(mk(1, 4'h5, 0, 0, 0, LK, 1, 2'd3));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].p);
      chk_all($sformatf("fail[%0d]", i), tbl[i].u, tbl[i].b, tbl[i].l, tbl[i].e, tbl[i].f);
    end

`ifdef SEQ_LOCK_LOCKOUT_EN
    n = 1; bad = 1'b0;
    for (int i = 0; i < 200 && lockout; i++) begin
      cyc(1'b1, 4'((i % 4) + 1), 1'b0);
      if (unlock) bad = 1'b1;
      if (lockout) n++;
    end
    chk("lockout_len", 32'(n), 32'd64);
    chk("lockout_ignored", 32'(bad), 32'd0);
    chk("lockout_fail_clr", 32'(fail_cnt), 32'd0);
`else
    cyc(1'b0, 4'h0, 1'b0);
    chk("no_lockout", 32'(lockout), 32'd0);
    enter(16'h1235, 1'b0);
    chk_all("saturate", 0, 0, 0, 1, 2'd3);
`endif
    enter(16'h1234, 1'b0);
    chk_all("after_fail_unlock", 1, 0, 0, 0, 2'd0);
    wait_closed("close1");

    // Timeout: 32 idle cycles abandon the attempt, 31 do not.
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    repeat (32) cyc(1'b0, 4'h0, 1'b0);
    chk("timeout_idle", 32'(unlock), 32'd0);
    enter(16'h1234, 1'b0);
    chk_all("timeout_unlock", 1, 0, 0, 0, 2'd0);
    wait_closed("close2");
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    repeat (31) cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h4, 1'b0);
    chk_all("timeout_edge", 1, 0, 0, 0, 2'd0);

    // Aborted reprogram keeps the old code.
    cyc(1'b1, 4'hA, 1'b1);
    chk_all("abort_a", 0, 1, 0, 0, 2'd0);
    cyc(1'b1, 4'hB, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk_all("abort_drop", 0, 0, 0, 0, 2'd0);
    enter(16'h1234, 1'b0);
    chk_all("abort_old_code", 1, 0, 0, 0, 2'd0);

    // Full reprogram to A,B,C,D.
    cyc(1'b1, 4'hA, 1'b1);
    chk_all("prog_a", 0, 1, 0, 0, 2'd0);
    cyc(1'b1, 4'hB, 1'b1);
    cyc(1'b1, 4'hC, 1'b1);
    chk_all("prog_c", 0, 1, 0, 0, 2'd0);
    cyc(1'b1, 4'hD, 1'b1);
    chk_all("prog_done", 0, 0, 0, 0, 2'd0);
    enter(16'h1234, 1'b0);
    chk_all("prog_old_rejected", 0, 0, 0, 1, 2'd1);
    enter(16'hABCD, 1'b0);
    chk_all("prog_new_unlock", 1, 0, 0, 0, 2'd0);

    // Clear mid-PROG: immediate reset, code reverts.
    cyc(1'b1, 4'h1, 1'b1);
    chk("clr_prog_pre", 32'(prog_busy), 32'd1);
    clear = 1'b0;
    #1;
    chk_all("clr_prog", 0, 0, 0, 0, 2'd0);
    sym_valid = 1'b0; prog_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    clear = 1'b1;
    enter(16'h1234, 1'b0);
    chk_all("clr_code_revert", 1, 0, 0, 0, 2'd0);
    wait_closed("close3");

    // Clear after the third failure (mid-LOCKOUT when built).
    repeat (3) enter(16'h1235, 1'b0);
    chk_all("clr_lock_pre", 0, 0, LK, 1, 2'd3);
    cyc(1'b0, 4'h0, 1'b0);
    clear = 1'b0;
    #1;
    chk_all("clr_lock", 0, 0, 0, 0, 2'd0);
    @(negedge clk);
    @(posedge clk);
    clear = 1'b1;
    enter(16'h1234, 1'b0);
    chk_all("clr_lock_unlock", 1, 0, 0, 0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
